// File: rtl/pipelined_control_unit.sv
// Decode and control pipeline for the 16-bit WISC-style 5-stage core.
// It decodes the IF/ID instruction into a control bundle and carries that
// bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects
// load-use hazards, applies branch flushes and keeps a sticky halt state.
//
// Handshake: id_valid qualifies id_instr. A zero id_instr is treated as a
// bubble. stall is combinational back-pressure: while it is high, the
// front end must hold PC and IF/ID so that the same instruction is offered
// again on the next cycle. flush kills whatever is in ID during that cycle.
module pipelined_control_unit #(
  parameter int INSTR_W    = 16,
  parameter int REG_ADDR_W = 4,
  parameter int ALUOP_W    = 3,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INSTR_W-1:0]    id_instr,
  input  logic                  id_valid,
  input  logic                  flush,
  output logic                  stall,
  output logic                  pc_hold,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic                  ex_alu_src,
  output logic [1:0]            ex_flags_set,
  output logic                  ex_branch,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_reg_write,
  output logic [1:0]            wb_data_src,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  halted
);

  // Full bundle held in ID/EX.
  typedef struct packed {
    logic                  is_lw;
    logic                  is_sw;
    logic                  is_br;
    logic                  is_hlt;
    logic [ALUOP_W-1:0]    alu_op;
    logic                  alu_src;
    logic [1:0]            flags_set;
    logic                  reg_write;
    logic [1:0]            data_src;
    logic [REG_ADDR_W-1:0] rd;
  } ex_ctrl_t;

  // Later stages keep only the fields they still consume.
  typedef struct packed {
    logic                  is_lw;
    logic                  is_sw;
    logic                  is_hlt;
    logic                  reg_write;
    logic [1:0]            data_src;
    logic [REG_ADDR_W-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic                  is_hlt;
    logic                  reg_write;
    logic [1:0]            data_src;
    logic [REG_ADDR_W-1:0] rd;
  } wb_ctrl_t;

  ex_ctrl_t  idex, dec;
  mem_ctrl_t exmem;
  wb_ctrl_t  memwb;

  // halt_pend: an HLT has left ID. It keeps pc_hold high and squashes ID.
  logic halt_pend;

  logic [3:0]            op;
  logic [REG_ADDR_W-1:0] f_rd, f_rs, f_rt;
  logic                  id_live;
  logic                  use_rs, use_rt, use_d;
  logic                  hazard;
  logic                  id_hlt;

  assign op   = id_instr[INSTR_W-1 -: 4];
  assign f_rd = id_instr[2*REG_ADDR_W +: REG_ADDR_W];
  assign f_rs = id_instr[REG_ADDR_W +: REG_ADDR_W];
  assign f_rt = id_instr[0 +: REG_ADDR_W];

  // Nothing past a retiring HLT is allowed to enter the pipe.
  assign id_live = id_valid && (id_instr != '0) && !halt_pend && !halted;

  // Decode the ID instruction into its control bundle and its source-register usage.
  always_comb begin
    dec    = '0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    use_d  = 1'b0;
    if (id_live) begin
      dec.rd        = f_rd;
      dec.alu_src   = 1'b1;
      dec.reg_write = 1'b1;
      dec.data_src  = 2'b01;
      if (!op[3]) dec.alu_op = ALUOP_W'(op[2:0]);
      case (op)
        4'h0, 4'h1: begin dec.alu_src = 1'b0; dec.flags_set = 2'b11; use_rs = 1'b1; use_rt = 1'b1; end
        4'h2, 4'h7: begin dec.alu_src = 1'b0; use_rs = 1'b1; use_rt = 1'b1; end
        4'h3:       begin dec.alu_src = 1'b0; dec.flags_set = 2'b01; use_rs = 1'b1; use_rt = 1'b1; end
        4'h4, 4'h5, 4'h6: begin dec.flags_set = 2'b01; use_rs = 1'b1; end
        4'h8:       begin dec.is_lw = 1'b1; dec.data_src = 2'b10; use_rs = 1'b1; end
        4'h9:       begin dec.is_sw = 1'b1; dec.reg_write = 1'b0; use_rs = 1'b1; use_d = 1'b1; end
        4'hA, 4'hB: begin dec.data_src = 2'b11; use_d = 1'b1; end
        4'hC:       begin dec.is_br = 1'b1; dec.alu_op = ALUOP_W'(1); dec.reg_write = 1'b0; end
        4'hD:       begin dec.is_br = 1'b1; dec.alu_op = ALUOP_W'(1); dec.reg_write = 1'b0; use_rs = 1'b1; end
        4'hE:       begin dec.alu_src = 1'b0; dec.data_src = 2'b00; end
        default:    begin dec.is_hlt = 1'b1; dec.reg_write = 1'b0; end
      endcase
      if ((ZERO_REG != 0) && (f_rd == '0)) dec.reg_write = 1'b0;
    end
  end

  // Load-use: the LW in EX targets a register that the ID instruction reads.
  always_comb begin
    hazard = 1'b0;
    if (idex.is_lw && !((ZERO_REG != 0) && (idex.rd == '0)))
      hazard = (use_rs && (f_rs == idex.rd)) ||
               (use_rt && (f_rt == idex.rd)) ||
               (use_d  && (f_rd == idex.rd));
  end

  assign stall   = hazard && !flush;
  assign id_hlt  = dec.is_hlt && !flush;
  assign pc_hold = halt_pend || id_hlt;

  assign ex_alu_op    = idex.alu_op;
  assign ex_alu_src   = idex.alu_src;
  assign ex_flags_set = idex.flags_set;
  assign ex_branch    = idex.is_br;
  assign mem_read     = exmem.is_lw;
  assign mem_write    = exmem.is_sw;
  assign wb_reg_write = memwb.reg_write;
  assign wb_data_src  = memwb.data_src;
  assign wb_rd        = memwb.rd;

  // Advance the stage registers, insert bubbles on flush/stall/halt, and track the halt state.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex      <= '0;
      exmem     <= '0;
      memwb     <= '0;
      halt_pend <= 1'b0;
      halted    <= 1'b0;
    end else begin
      idex  <= (flush || stall || halted) ? '0 : dec;
      exmem <= halted ? '0 : '{is_lw: idex.is_lw, is_sw: idex.is_sw, is_hlt: idex.is_hlt,
                               reg_write: idex.reg_write, data_src: idex.data_src, rd: idex.rd};
      memwb <= halted ? '0 : '{is_hlt: exmem.is_hlt, reg_write: exmem.reg_write,
                               data_src: exmem.data_src, rd: exmem.rd};
      if (id_hlt) halt_pend <= 1'b1;
      if (memwb.is_hlt) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit. The driver applies one input
// vector per cycle and queues the hand-computed output vector for that cycle.
// The monitor pops the queued vector and compares it on the falling edge.
module tb_pipelined_control_unit;

  localparam int W = 19;
  localparam logic [W-1:0] ALL = '1;
  localparam logic [W-1:0] Z   = '0;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] id_instr;
  logic        id_valid;
  logic        flush;
  logic        stall, pc_hold, ex_alu_src, ex_branch, mem_read, mem_write;
  logic        wb_reg_write, halted;
  logic [2:0]  ex_alu_op;
  logic [1:0]  ex_flags_set, wb_data_src;
  logic [3:0]  wb_rd;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        name_q[$];
  int           checks = 0;
  int           failures = 0;

  pipelined_control_unit dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
    .stall(stall), .pc_hold(pc_hold), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_flags_set(ex_flags_set), .ex_branch(ex_branch), .mem_read(mem_read),
    .mem_write(mem_write), .wb_reg_write(wb_reg_write), .wb_data_src(wb_data_src),
    .wb_rd(wb_rd), .halted(halted)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Output vector layout: stall, pc_hold, alu_op, alu_src, flags, branch,
  // mem_read, mem_write, reg_write, data_src, rd, halted.
  function automatic logic [W-1:0] pk(input logic s, input logic ph, input logic [2:0] aop,
                                      input logic src, input logic [1:0] fs, input logic br,
                                      input logic mr, input logic mw, input logic rw,
                                      input logic [1:0] ds, input logic [3:0] rd, input logic h);
    return {s, ph, aop, src, fs, br, mr, mw, rw, ds, rd, h};
  endfunction

  // driver: one cycle of stimulus plus its expected outputs
  task automatic step(input logic r, input logic [15:0] ins, input logic v, input logic fl,
                      input logic [W-1:0] m, input logic [W-1:0] e, input string nm);
    @(posedge clk);
    #1;
    rst      = r;
    id_instr = ins;
    id_valid = v;
    flush    = fl;
    exp_q.push_back(e);
    mask_q.push_back(m);
    name_q.push_back(nm);
  endtask

  task automatic idle(input logic [W-1:0] e, input string nm);
    step(1'b0, 16'h0000, 1'b0, 1'b0, ALL, e, nm);
  endtask

  // scoreboard monitor
  logic [W-1:0] mon_act, mon_exp, mon_mask;
  string        mon_name;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp  = exp_q.pop_front();
      mon_mask = mask_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = {stall, pc_hold, ex_alu_op, ex_alu_src, ex_flags_set, ex_branch,
                  mem_read, mem_write, wb_reg_write, wb_data_src, wb_rd, halted};
      if (mon_mask != '0) begin
        checks++;
        if ((mon_act & mon_mask) !== (mon_exp & mon_mask)) begin
          failures++;
          $display("FAIL %s act=%h exp=%h", mon_name, mon_act & mon_mask, mon_exp & mon_mask);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; id_instr = '0; id_valid = 1'b0; flush = 1'b0;
    step(1'b1, 16'h0000, 1'b0, 1'b0, Z, Z, "reset_cycle");

    // SUB r1,r2,r3
    step(1'b0, 16'h1123, 1'b1, 1'b0, ALL, Z, "reset_zero");
    idle(pk(0,0,3'b001,0,2'b11,0,0,0,0,2'b00,4'd0,0), "sub_ex");
    idle(Z, "sub_mem");
    idle(pk(0,0,3'b000,0,2'b00,0,0,0,1,2'b01,4'd1,0), "sub_wb");

    // LW r4 then dependent ADD r5,r4,r6
    step(1'b0, 16'h8450, 1'b1, 1'b0, ALL, Z, "lw_id");
    step(1'b0, 16'h0546, 1'b1, 1'b0, ALL, pk(1,0,0,1,0,0,0,0,0,0,0,0), "lu_stall");
    step(1'b0, 16'h0546, 1'b1, 1'b0, ALL, pk(0,0,0,0,0,0,1,0,0,0,0,0), "lu_bubble_memrd");
    idle(pk(0,0,0,0,2'b11,0,0,0,1,2'b10,4'd4,0), "lu_add_ex_lw_wb");
    idle(Z, "lu_add_mem");
    idle(pk(0,0,0,0,0,0,0,0,1,2'b01,4'd5,0), "lu_add_wb");

    // LW r0 then ADD r1,r0,r2: r0 never hazards
    step(1'b0, 16'h8020, 1'b1, 1'b0, ALL, Z, "lw0_id");
    step(1'b0, 16'h0102, 1'b1, 1'b0, ALL, pk(0,0,0,1,0,0,0,0,0,0,0,0), "lw0_nostall");
    idle(pk(0,0,0,0,2'b11,0,1,0,0,0,0,0), "lw0_add_ex");
    idle(pk(0,0,0,0,0,0,0,0,0,2'b10,4'd0,0), "lw0_wb_norw");
    idle(pk(0,0,0,0,0,0,0,0,1,2'b01,4'd1,0), "lw0_add_wb");

    // load-use hazard coinciding with flush
    step(1'b0, 16'h8450, 1'b1, 1'b0, ALL, Z, "lf_lw_id");
    step(1'b0, 16'h0546, 1'b1, 1'b1, ALL, pk(0,0,0,1,0,0,0,0,0,0,0,0), "lf_flush_wins");
    idle(pk(0,0,0,0,0,0,1,0,0,0,0,0), "lf_ex_bubble");
    idle(pk(0,0,0,0,0,0,0,0,1,2'b10,4'd4,0), "lf_lw_wb");
    idle(Z, "lf_drain");

    // B then XOR r2,r3,r4
    step(1'b0, 16'hC000, 1'b1, 1'b0, ALL, Z, "b_id");
    step(1'b0, 16'h3234, 1'b1, 1'b0, ALL, pk(0,0,3'b001,1,0,1,0,0,0,0,0,0), "b_ex");
    idle(pk(0,0,3'b011,0,2'b01,0,0,0,0,0,0,0), "xor_ex");
    idle(pk(0,0,0,0,0,0,0,0,0,2'b01,4'd0,0), "b_wb_norw");
    idle(pk(0,0,0,0,0,0,0,0,1,2'b01,4'd2,0), "xor_wb");

    // flushed HLT, then a real HLT
    step(1'b0, 16'hF000, 1'b1, 1'b1, ALL, Z, "hlt_flushed");
    idle(Z, "hlt_flushed_bubble");
    step(1'b0, 16'hF000, 1'b1, 1'b0, ALL, pk(0,1,0,0,0,0,0,0,0,0,0,0), "hlt_pc_hold");
    idle(pk(0,1,0,1,0,0,0,0,0,0,0,0), "hlt_ex");
    idle(pk(0,1,0,0,0,0,0,0,0,0,0,0), "hlt_mem");
    idle(pk(0,1,0,0,0,0,0,0,0,2'b01,4'd0,0), "hlt_wb");
    idle(pk(0,1,0,0,0,0,0,0,0,0,0,1), "halted_set");
    step(1'b0, 16'h0123, 1'b1, 1'b0, ALL, pk(0,1,0,0,0,0,0,0,0,0,0,1), "halted_sticky");
    idle(pk(0,1,0,0,0,0,0,0,0,0,0,1), "halted_squash");

    // reset while halted with a load in ID, then PCS r7
    step(1'b1, 16'h8450, 1'b1, 1'b0, ALL, pk(0,1,0,0,0,0,0,0,0,0,0,1), "rst_sampled");
    idle(Z, "rst_all_zero");
    step(1'b0, 16'hE700, 1'b1, 1'b0, ALL, Z, "pcs_id");
    idle(Z, "pcs_ex");
    idle(Z, "pcs_mem");
    idle(pk(0,0,0,0,0,0,0,0,1,2'b00,4'd7,0), "pcs_wb");

    // final report
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain act=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Decode-plus-control-pipeline for the 16-bit WISC-style 5-stage core.
- Decodes the instruction held in the IF/ID register into a control bundle.
- Carries that bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles.
- Applies branch flushes.
- Latches HLT into a sticky halted state.
- Replaces the single-cycle combinational decoder and is the sole source of per-stage control.

Parameters:
INSTR_W, 16, instruction width; opcode is always the top 4 bits.
REG_ADDR_W, 4, register specifier width; fields are rd=[11:8], rs=[7:4], rt=[3:0] at default.
ALUOP_W, 3, ALU operation code width.
ZERO_REG, 1, 1 = register 0 is hardwired, so it never creates a hazard and never asserts reg_write.

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous active-high reset
id_instr  in  INSTR_W  instruction in the IF/ID register
id_valid  in  1  id_instr is a real instruction; 0 = bubble
flush  in  1  branch taken in EX; kill the ID instruction
stall  out  1  hold PC and IF/ID this cycle (load-use)
pc_hold  out  1  stop fetch; HLT is in ID or later
ex_alu_op  out  ALUOP_W  ALU op for the EX instruction
ex_alu_src  out  1  0 = register operand, 1 = immediate
ex_flags_set  out  2  flag update class: 11 = Z/V/N, 01 = Z only, 00 = none
ex_branch  out  1  EX instruction is B/BR
mem_read  out  1  MEM instruction is LW
mem_write  out  1  MEM instruction is SW
wb_reg_write  out  1  WB instruction writes the register file
wb_data_src  out  2  00 = PC+2, 01 = ALU, 10 = memory, 11 = LHB/LLB
wb_rd  out  REG_ADDR_W  WB destination register
halted  out  1  HLT has retired; sticky until rst

Behaviour:
Decode (combinational in ID, registered into ID/EX):
- Opcodes: ADD 0, SUB 1, RED 2, XOR 3, SLL 4, SRA 5, ROR 6, PADDSB 7, LW 8, SW 9, LHB A, LLB B, B C, BR D, PCS E, HLT F.
- ALU op: opcode[2:0] for opcodes 0-7; 001 for B/BR; 000 otherwise.
- flags_set: 11 for ADD/SUB; 01 for XOR/SLL/SRA/ROR; 00 otherwise.
- alu_src: 0 for ADD/SUB/RED/XOR/PADDSB/PCS; 1 otherwise.
- reg_write: 0 for SW/B/BR/HLT; 1 otherwise.
- data_src: LW 10; LHB/LLB 11; PCS 00; else 01.
- id_instr == 0 or id_valid == 0 decodes as a bubble: all enables 0, alu_op 000.
- With ZERO_REG = 1, rd == 0 forces reg_write to 0.

Source registers for hazard checks:
- rs and rt: ADD/SUB/RED/XOR/PADDSB.
- rs only: SLL/SRA/ROR/LW/BR.
- rs and [11:8]: SW.
- [11:8] only: LHB/LLB.
- none: B/PCS/HLT/bubble.

Pipeline:
- Each cycle the bundle advances ID/EX -> EX/MEM -> MEM/WB.
- Outputs are driven from the registers: ex_* from ID/EX, mem_* from EX/MEM, wb_* from MEM/WB.
- Decode-to-EX latency is 1 cycle; decode-to-WB latency is 3 cycles.

Load-use stall:
- stall = 1 (combinational) when ID/EX holds a valid LW with rd == R, and R is a source of the ID instruction.
- R == 0 is excluded when ZERO_REG = 1.
- While stalled, ID/EX loads a bubble and later stages advance normally.
- Stall lasts exactly 1 cycle per hazard.

Flush:
- flush = 1 loads a bubble into ID/EX.
- flush has priority over stall: stall is forced to 0 whenever flush = 1.
- A flushed HLT does not set pc_hold.

Halt:
- pc_hold asserts combinationally when a valid, unflushed HLT is in ID.
- pc_hold then stays 1 (registered) while the HLT is in EX, MEM or WB, and afterwards.
- halted sets the cycle after HLT occupies MEM/WB and stays 1.
- Once halted, all stage registers hold bubbles.

Reset (synchronous):
- All stage registers are cleared to bubbles.
- stall, pc_hold and halted go to 0; every output reads 0 in the cycle after rst is sampled high.
- Reset in mid-stall or mid-halt discards all state; no partial completion.

Simultaneous events:
- A load-use hazard on an HLT in ID cannot occur, since HLT has no sources.
- stall and flush together: flush wins.

Test Plan:
1. Reset, then id_instr=0x1123 (SUB r1,r2,r3) -> next cycle ex_alu_op=001, ex_flags_set=11, ex_alu_src=0. Two cycles later wb_reg_write=1, wb_data_src=01, wb_rd=1.
2. LW r4 (0x8450) followed by ADD r5,r4,r6 (0x0546) -> stall=1 for exactly one cycle and ID/EX gets a bubble. ADD reaches EX one cycle late. mem_read=1 when LW is in MEM.
3. LW r0 then ADD r1,r0,r2 with ZERO_REG=1 -> no stall; the LW has wb_reg_write=0.
4. HLT (0xF000) in ID with flush=1 -> ID/EX holds a bubble and pc_hold stays 0. Same HLT without flush -> pc_hold=1 immediately, halted=1 four cycles after decode, sticky thereafter.
5. Load-use hazard with flush=1 in the same cycle -> stall=0 and ID/EX holds a bubble.
6. rst asserted while halted=1 with a stall pending -> next cycle all outputs 0. Then decode PCS (0xE700) -> wb_data_src=00, wb_reg_write=1, wb_rd=7.
